smc_ahb_mcs_if: RTL and testbench

- Parametrised AHB-lite slave front end for the static memory controller: NUM_CS external banks, configurable address/data width.
- Registers the address phase and decodes the bank chip select.
- Launches one access per transfer to the SMC core state machine and generates all AHB responses: wait states, two-cycle ERROR.
- Sits between the AHB decoder/mux and the SMC core; bank enables come from the SMC config register block.

---
 rtl/smc_ahb_mcs_if.sv | 359 +++++++++++++++++++++++++++++++++++
 tb/tb_smc_ahb_mcs_if.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smc_ahb_mcs_if.sv
// ---------------------------------------------------------------------------
// smc_ahb_mcs_if
// AHB-lite slave front end of the static memory controller.
// Registers the AHB address phase and decodes the bank chip select. It
// launches one access per transfer to the SMC core and generates the AHB
// response: wait states while the core works, and a two-cycle ERROR for
// illegal transfers.
//
// Optional feature macro: SMC_AHB_WRBUF_EN
//   Adds a single-entry posted write buffer. A legal write completes on AHB
//   with zero wait states while the core drains it. A request that arrives
//   while the drain is in progress is held with smc_hready=0 until the core
//   finishes.
//
// Ports
//   hclk, n_sys_reset        clock, async active-low reset
//   hsel, haddr, htrans,     AHB address/control from the decoder/mux
//   hwrite, hsize, hwdata,
//   hready
//   cs_enable                per-bank enable from the config block
//   smc_idle, smc_done,      core status: idle, last cycle of an access,
//   mac_done                 and all beats of the transfer done
//   read_data                core read data
//   smc_hrdata, smc_hready,  AHB slave response
//   smc_hresp
//   new_access               one-cycle launch strobe to the core
//   addr, cs, xfer_size,     registered access attributes for the core
//   n_read, write_data
// ---------------------------------------------------------------------------
module smc_ahb_mcs_if #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int NUM_CS = 4,
  parameter int CS_LSB = 24
) (
  input  logic              hclk,
  input  logic              n_sys_reset,
  input  logic              hsel,
  input  logic [AW-1:0]     haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DW-1:0]     hwdata,
  input  logic              hready,
  input  logic [NUM_CS-1:0] cs_enable,
  input  logic              smc_idle,
  input  logic              smc_done,
  input  logic              mac_done,
  input  logic [DW-1:0]     read_data,
  output logic [DW-1:0]     smc_hrdata,
  output logic              smc_hready,
  output logic [1:0]        smc_hresp,
  output logic              new_access,
  output logic [AW-1:0]     addr,
  output logic [NUM_CS-1:0] cs,
  output logic [1:0]        xfer_size,
  output logic              n_read,
  output logic [DW-1:0]     write_data
);

  localparam int         MAX_SIZE   = (DW == 64) ? 3 : 2;
  localparam int         BW         = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PEND = 3'd1,
    ST_BUSY = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic                valid_s;
  logic                done_s;
  logic                size_err_s;
  logic                align_err_s;
  logic                req_err_s;
  logic [BW-1:0]       bank_s;
  logic [NUM_CS-1:0]   cs_dec_s;
  logic                take_s;
  logic                load_req_s;
  logic                launch_s;
  logic                hready_s;
  logic [1:0]          hresp_s;
  logic                wr_cap_r;
  logic                new_access_r;
  logic [AW-1:0]       addr_r;
  logic [NUM_CS-1:0]   cs_r;
  logic [1:0]          xfer_size_r;
  logic                n_read_r;
  logic [DW-1:0]       write_data_r;

`ifdef SMC_AHB_WRBUF_EN
  logic                hold_s;
  logic                take_held_s;
  logic                load_hold_s;
  logic                posted_r;
  logic                held_r;
  logic [AW-1:0]       hold_addr_r;
  logic [NUM_CS-1:0]   hold_cs_r;
  logic [1:0]          hold_size_r;
  logic                hold_wr_r;
  logic                hold_err_r;
`endif

  assign valid_s = hsel & hready & htrans[1];
  assign done_s  = smc_done & mac_done;

  // Bank-select field; a single bank has no field and always selects bank 0.
  generate
    if (NUM_CS > 1) begin : g_bank
      assign bank_s = haddr[CS_LSB +: BW];
    end else begin : g_bank1
      assign bank_s = 1'b0;
    end
  endgenerate

  // Transfer legality: size wider than the bus, misalignment, disabled bank.
  always_comb begin
    size_err_s = (hsize > 3'(MAX_SIZE));
    case (hsize)
      3'd1:    align_err_s = haddr[0];
      3'd2:    align_err_s = |haddr[1:0];
      3'd3:    align_err_s = |haddr[2:0];
      default: align_err_s = 1'b0;
    endcase
    req_err_s = size_err_s | align_err_s | ~cs_enable[bank_s];
  end

  // One-hot chip select decode of the bank field.
  always_comb begin
    cs_dec_s = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      cs_dec_s[i] = (32'(bank_s) == i);
    end
  end

  // Next-state, launch and AHB response logic.
  always_comb begin
    state_nx_s = state_r;
    hready_s   = 1'b1;
    hresp_s    = RESP_OKAY;
    take_s     = 1'b0;
    load_req_s = 1'b0;
    launch_s   = 1'b0;
`ifdef SMC_AHB_WRBUF_EN
    hold_s      = 1'b0;
    take_held_s = 1'b0;
    load_hold_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (valid_s) begin
          take_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PEND: begin
`ifdef SMC_AHB_WRBUF_EN
        // A posted write needs no AHB stall; a new request gets parked.
        if (posted_r && !held_r) begin
          hready_s = 1'b1;
          hold_s   = valid_s;
        end else begin
          hready_s = 1'b0;
        end
`else
        hready_s = 1'b0;
`endif
        if (smc_idle) begin
          state_nx_s = ST_BUSY;
          launch_s   = 1'b1;
        end else begin
          state_nx_s = ST_PEND;
        end
      end
      ST_BUSY: begin
`ifdef SMC_AHB_WRBUF_EN
        if (posted_r && held_r) begin
          hready_s = 1'b0;
          if (done_s) begin
            take_held_s = 1'b1;
          end else begin
            state_nx_s = ST_BUSY;
          end
        end else if (posted_r) begin
          hready_s = 1'b1;
          if (valid_s && done_s) begin
            take_s = 1'b1;
          end else if (valid_s) begin
            hold_s = 1'b1;
          end else if (done_s) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_BUSY;
          end
        end else begin
          hready_s = done_s;
          if (done_s && valid_s) begin
            take_s = 1'b1;
          end else if (done_s) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_BUSY;
          end
        end
`else
        hready_s = done_s;
        if (done_s && valid_s) begin
          take_s = 1'b1;
        end else if (done_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_BUSY;
        end
`endif
      end
      ST_ERR1: begin
        hready_s   = 1'b0;
        hresp_s    = RESP_ERROR;
        state_nx_s = ST_ERR2;
      end
      ST_ERR2: begin
        // Whatever is sampled here is dropped; the master must cancel.
        hready_s   = 1'b1;
        hresp_s    = RESP_ERROR;
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    // Accept a request straight off the bus (from IDLE or back-to-back).
    if (take_s) begin
      if (req_err_s) begin
        state_nx_s = ST_ERR1;
      end else begin
        load_req_s = 1'b1;
        if (smc_idle) begin
          state_nx_s = ST_BUSY;
          launch_s   = 1'b1;
        end else begin
          state_nx_s = ST_PEND;
        end
      end
    end else begin
      load_req_s = 1'b0;
    end

`ifdef SMC_AHB_WRBUF_EN
    // Release the request parked behind a draining posted write.
    if (take_held_s) begin
      if (hold_err_r) begin
        state_nx_s = ST_ERR1;
      end else begin
        load_hold_s = 1'b1;
        if (smc_idle) begin
          state_nx_s = ST_BUSY;
          launch_s   = 1'b1;
        end else begin
          state_nx_s = ST_PEND;
        end
      end
    end else begin
      load_hold_s = 1'b0;
    end
`endif
  end

  // State register and registered access attributes.
  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      state_r      <= ST_IDLE;
      new_access_r <= 1'b0;
      addr_r       <= '0;
      cs_r         <= '0;
      xfer_size_r  <= 2'b00;
      n_read_r     <= 1'b0;
      wr_cap_r     <= 1'b0;
      write_data_r <= '0;
    end else begin
      state_r      <= state_nx_s;
      new_access_r <= launch_s;
      if (load_req_s) begin
        addr_r      <= haddr;
        cs_r        <= cs_dec_s;
        xfer_size_r <= hsize[1:0];
        n_read_r    <= hwrite;
      end
`ifdef SMC_AHB_WRBUF_EN
      else if (load_hold_s) begin
        addr_r      <= hold_addr_r;
        cs_r        <= hold_cs_r;
        xfer_size_r <= hold_size_r;
        n_read_r    <= hold_wr_r;
      end
      wr_cap_r <= (load_req_s & hwrite) | (load_hold_s & hold_wr_r);
`else
      wr_cap_r <= load_req_s & hwrite;
`endif
      // hwdata is valid in the data phase, i.e. one edge after the load.
      if (wr_cap_r) begin
        write_data_r <= hwdata;
      end
    end
  end

`ifdef SMC_AHB_WRBUF_EN
  // Posted-write tracking and the parked-request holding register.
  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      posted_r    <= 1'b0;
      held_r      <= 1'b0;
      hold_addr_r <= '0;
      hold_cs_r   <= '0;
      hold_size_r <= 2'b00;
      hold_wr_r   <= 1'b0;
      hold_err_r  <= 1'b0;
    end else begin
      if (load_req_s) begin
        posted_r <= hwrite;
      end else if (load_hold_s) begin
        posted_r <= hold_wr_r;
      end else if ((state_nx_s == ST_IDLE) || (state_nx_s == ST_ERR1)) begin
        posted_r <= 1'b0;
      end
      if (hold_s) begin
        held_r      <= 1'b1;
        hold_addr_r <= haddr;
        hold_cs_r   <= cs_dec_s;
        hold_size_r <= hsize[1:0];
        hold_wr_r   <= hwrite;
        hold_err_r  <= req_err_s;
      end else if (take_held_s) begin
        held_r <= 1'b0;
      end
    end
  end

  assign smc_hrdata = ((state_r == ST_BUSY) && !posted_r) ? read_data : '0;
`else
  assign smc_hrdata = (state_r == ST_BUSY) ? read_data : '0;
`endif

  assign smc_hready = hready_s;
  assign smc_hresp  = hresp_s;
  assign new_access = new_access_r;
  assign addr       = addr_r;
  assign cs         = cs_r;
  assign xfer_size  = xfer_size_r;
  assign n_read     = n_read_r;
  assign write_data = write_data_r;

endmodule

// File: tb/tb_smc_ahb_mcs_if.sv
// ---------------------------------------------------------------------------
// tb_smc_ahb_mcs_if
// Directed bench for smc_ahb_mcs_if (DW=32, NUM_CS=4, CS_LSB=24). The bus
// ready input is looped back from smc_hready as the AHB mux would do. The
// core handshakes are driven cycle by cycle. Inputs change 1 time unit after
// the rising edge and outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_smc_ahb_mcs_if;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int NUM_CS = 4;

  logic              hclk = 1'b0;
  logic              n_sys_reset;
  logic              hsel;
  logic [AW-1:0]     haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DW-1:0]     hwdata;
  logic              hready;
  logic [NUM_CS-1:0] cs_enable;
  logic              smc_idle;
  logic              smc_done;
  logic              mac_done;
  logic [DW-1:0]     read_data;
  logic [DW-1:0]     smc_hrdata;
  logic              smc_hready;
  logic [1:0]        smc_hresp;
  logic              new_access;
  logic [AW-1:0]     addr;
  logic [NUM_CS-1:0] cs;
  logic [1:0]        xfer_size;
  logic              n_read;
  logic [DW-1:0]     write_data;

  int tests_run    = 0;
  int tests_failed = 0;

  smc_ahb_mcs_if #(.AW(AW), .DW(DW), .NUM_CS(NUM_CS), .CS_LSB(24)) dut (
    .hclk        (hclk),
    .n_sys_reset (n_sys_reset),
    .hsel        (hsel),
    .haddr       (haddr),
    .htrans      (htrans),
    .hwrite      (hwrite),
    .hsize       (hsize),
    .hwdata      (hwdata),
    .hready      (hready),
    .cs_enable   (cs_enable),
    .smc_idle    (smc_idle),
    .smc_done    (smc_done),
    .mac_done    (mac_done),
    .read_data   (read_data),
    .smc_hrdata  (smc_hrdata),
    .smc_hready  (smc_hready),
    .smc_hresp   (smc_hresp),
    .new_access  (new_access),
    .addr        (addr),
    .cs          (cs),
    .xfer_size   (xfer_size),
    .n_read      (n_read),
    .write_data  (write_data)
  );

  always #5 hclk = ~hclk;

  assign hready = smc_hready;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge hclk);
  endtask

  task automatic req(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic [2:0] sz);
    hsel   = 1'b1;
    htrans = tr;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = 32'h0;
    hwrite = 1'b0;
    hsize  = 3'd0;
  endtask

  task automatic set_done(input logic d);
    smc_done = d;
    mac_done = d;
  endtask

  initial begin
    n_sys_reset = 1'b0;
    bus_idle();
    hwdata    = 32'h0;
    cs_enable = 4'b1111;
    smc_idle  = 1'b1;
    set_done(1'b0);
    read_data = 32'h0;

    // Reset values
    #12;
    check_eq("rst_hready", smc_hready, 64'd1);
    check_eq("rst_hresp", smc_hresp, 64'd0);
    check_eq("rst_new_access", new_access, 64'd0);
    check_eq("rst_cs", cs, 64'd0);
    check_eq("rst_addr", addr, 64'd0);
    check_eq("rst_xfer_size", xfer_size, 64'd0);
    check_eq("rst_n_read", n_read, 64'd0);
    check_eq("rst_write_data", write_data, 64'd0);
    check_eq("rst_hrdata", smc_hrdata, 64'd0);
    n_sys_reset = 1'b1;

    // Word read at 0x0200_0010, core done after three wait cycles
    tick(); req(2'b10, 32'h0200_0010, 1'b0, 3'd2);
    at_neg(); check_eq("rd_addr_phase_ready", smc_hready, 64'd1);
    tick(); bus_idle();
    at_neg();
    check_eq("rd_new_access", new_access, 64'd1);
    check_eq("rd_cs", cs, 64'h4);
    check_eq("rd_addr", addr, 64'h0200_0010);
    check_eq("rd_xfer_size", xfer_size, 64'd2);
    check_eq("rd_n_read", n_read, 64'd0);
    check_eq("rd_wait1", smc_hready, 64'd0);
    tick(); at_neg();
    check_eq("rd_new_access_once", new_access, 64'd0);
    check_eq("rd_wait2", smc_hready, 64'd0);
    tick(); at_neg();
    check_eq("rd_wait3", smc_hready, 64'd0);
    tick(); set_done(1'b1); read_data = 32'hCAFE_F00D;
    at_neg();
    check_eq("rd_done_ready", smc_hready, 64'd1);
    check_eq("rd_hrdata", smc_hrdata, 64'hCAFE_F00D);
    check_eq("rd_hresp", smc_hresp, 64'd0);
    tick(); set_done(1'b0);
    at_neg();
    check_eq("rd_idle_ready", smc_hready, 64'd1);
    check_eq("rd_idle_hrdata", smc_hrdata, 64'd0);

    // Misaligned word write -> two-cycle ERROR, no access
    tick(); req(2'b10, 32'h0000_0002, 1'b1, 3'd2);
    at_neg();
    tick(); bus_idle();
    at_neg();
    check_eq("mis_err1_ready", smc_hready, 64'd0);
    check_eq("mis_err1_resp", smc_hresp, 64'd1);
    check_eq("mis_err1_no_access", new_access, 64'd0);
    check_eq("mis_err1_cs", cs, 64'h4);
    tick(); at_neg();
    check_eq("mis_err2_ready", smc_hready, 64'd1);
    check_eq("mis_err2_resp", smc_hresp, 64'd1);
    check_eq("mis_err2_no_access", new_access, 64'd0);
    tick(); at_neg();
    check_eq("mis_after_resp", smc_hresp, 64'd0);
    check_eq("mis_after_cs", cs, 64'h4);
    check_eq("mis_after_n_read", n_read, 64'd0);

    // Disabled bank 1 -> two-cycle ERROR, no access
    tick(); cs_enable = 4'b1101; req(2'b10, 32'h0100_0000, 1'b0, 3'd2);
    at_neg();
    tick(); bus_idle();
    at_neg();
    check_eq("dis_err1_ready", smc_hready, 64'd0);
    check_eq("dis_err1_resp", smc_hresp, 64'd1);
    tick(); at_neg();
    check_eq("dis_err2_ready", smc_hready, 64'd1);
    check_eq("dis_err2_resp", smc_hresp, 64'd1);
    check_eq("dis_no_access", new_access, 64'd0);
    tick(); cs_enable = 4'b1111;
    at_neg();
    check_eq("dis_after_cs", cs, 64'h4);
    check_eq("dis_after_addr", addr, 64'h0200_0010);

    // Oversized transfer (doubleword on a 32-bit bus) -> ERROR
    tick(); req(2'b10, 32'h0000_0000, 1'b0, 3'd3);
    at_neg();
    tick(); bus_idle();
    at_neg(); check_eq("size_err1_resp", smc_hresp, 64'd1);
    tick(); at_neg();
    tick(); at_neg(); check_eq("size_after_resp", smc_hresp, 64'd0);

    // Core busy for four cycles at request -> PEND
    tick(); smc_idle = 1'b0; req(2'b10, 32'h0300_0010, 1'b0, 3'd2);
    at_neg();
    tick(); bus_idle();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) smc_idle = 1'b1;
      at_neg();
      check_eq($sformatf("pend_ready_%0d", i), smc_hready, 64'd0);
      check_eq($sformatf("pend_no_access_%0d", i), new_access, 64'd0);
      tick();
    end
    set_done(1'b1); read_data = 32'h1111_2222;
    at_neg();
    check_eq("pend_new_access", new_access, 64'd1);
    check_eq("pend_cs", cs, 64'h8);
    check_eq("pend_done_ready", smc_hready, 64'd1);
    check_eq("pend_hrdata", smc_hrdata, 64'h1111_2222);
    tick(); set_done(1'b0);
    at_neg();
    check_eq("pend_idle_ready", smc_hready, 64'd1);
    check_eq("pend_idle_access", new_access, 64'd0);

    // Back-to-back reads 0x0, 0x4 with no bubble
    tick(); req(2'b10, 32'h0000_0000, 1'b0, 3'd2);
    at_neg();
    tick(); req(2'b11, 32'h0000_0004, 1'b0, 3'd2);
    at_neg();
    check_eq("b2b_first_access", new_access, 64'd1);
    check_eq("b2b_first_cs", cs, 64'h1);
    check_eq("b2b_first_wait", smc_hready, 64'd0);
    tick(); set_done(1'b1); read_data = 32'hAAAA_0001;
    at_neg();
    check_eq("b2b_first_ready", smc_hready, 64'd1);
    check_eq("b2b_first_hrdata", smc_hrdata, 64'hAAAA_0001);
    tick(); bus_idle(); read_data = 32'hBBBB_0002;
    at_neg();
    check_eq("b2b_second_access", new_access, 64'd1);
    check_eq("b2b_second_addr", addr, 64'h4);
    check_eq("b2b_second_ready", smc_hready, 64'd1);
    check_eq("b2b_second_hrdata", smc_hrdata, 64'hBBBB_0002);
    tick(); set_done(1'b0);
    at_neg();
    check_eq("b2b_idle_access", new_access, 64'd0);

`ifdef SMC_AHB_WRBUF_EN
    // Posted write then an immediate read
    tick(); req(2'b10, 32'h0000_0010, 1'b1, 3'd2);
    at_neg();
    tick(); req(2'b10, 32'h0000_0020, 1'b0, 3'd2); hwdata = 32'hA5A5_5A5A;
    at_neg();
    check_eq("wb_wr_zero_wait", smc_hready, 64'd1);
    check_eq("wb_wr_resp", smc_hresp, 64'd0);
    check_eq("wb_wr_access", new_access, 64'd1);
    check_eq("wb_wr_n_read", n_read, 64'd1);
    tick(); bus_idle();
    at_neg();
    check_eq("wb_rd_stall", smc_hready, 64'd0);
    check_eq("wb_wr_data", write_data, 64'hA5A5_5A5A);
    check_eq("wb_wr_addr_held", addr, 64'h10);
    tick(); set_done(1'b1);
    at_neg();
    check_eq("wb_rd_stall_at_wr_done", smc_hready, 64'd0);
    tick(); set_done(1'b0); read_data = 32'h0BAD_BEEF;
    at_neg();
    check_eq("wb_rd_access", new_access, 64'd1);
    check_eq("wb_rd_addr", addr, 64'h20);
    check_eq("wb_rd_n_read", n_read, 64'd0);
    check_eq("wb_rd_wait", smc_hready, 64'd0);
    tick(); set_done(1'b1);
    at_neg();
    check_eq("wb_rd_ready", smc_hready, 64'd1);
    check_eq("wb_rd_hrdata", smc_hrdata, 64'h0BAD_BEEF);
    tick(); set_done(1'b0); hwdata = 32'h0;
    at_neg();
    check_eq("wb_idle_access", new_access, 64'd0);
`else
    // Non-posted write waits for the core like a read
    tick(); req(2'b10, 32'h0000_0008, 1'b1, 3'd2);
    at_neg();
    tick(); bus_idle(); hwdata = 32'h1234_5678;
    at_neg();
    check_eq("wr_access", new_access, 64'd1);
    check_eq("wr_n_read", n_read, 64'd1);
    check_eq("wr_wait", smc_hready, 64'd0);
    check_eq("wr_data_not_yet", write_data, 64'd0);
    tick(); at_neg();
    check_eq("wr_data", write_data, 64'h1234_5678);
    check_eq("wr_wait2", smc_hready, 64'd0);
    tick(); set_done(1'b1);
    at_neg();
    check_eq("wr_done_ready", smc_hready, 64'd1);
    check_eq("wr_done_resp", smc_hresp, 64'd0);
    tick(); set_done(1'b0); hwdata = 32'h0;
    at_neg();
    check_eq("wr_idle_ready", smc_hready, 64'd1);
`endif

    // Reset asserted in the middle of an access
    tick(); req(2'b10, 32'h0200_0000, 1'b0, 3'd2);
    at_neg();
    tick(); bus_idle();
    at_neg();
    check_eq("mrst_busy_wait", smc_hready, 64'd0);
    #2 n_sys_reset = 1'b0;
    #1;
    check_eq("mrst_ready", smc_hready, 64'd1);
    check_eq("mrst_access", new_access, 64'd0);
    check_eq("mrst_cs", cs, 64'd0);
    check_eq("mrst_addr", addr, 64'd0);
    check_eq("mrst_write_data", write_data, 64'd0);
    tick(); n_sys_reset = 1'b1;
    tick(); at_neg();
    check_eq("mrst_after_ready", smc_hready, 64'd1);
    check_eq("mrst_after_resp", smc_hresp, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
